cal_sweep_sequencer: RTL
========================

# cal_sweep_sequencer

Sequences a full LED calibration sweep: it lights one LED at a time, waits for the strand update and for the camera to settle, then requests a frame capture/scan. It steps through every LED index from 0 to NUM_LEDS-1 and then reports completion. It sits between the user controls and the calibration FSM, replacing manual increment/capture button presses with a timed, handshaked sweep.

## Interface
Parameters:
- NUM_LEDS, 50, LEDs in the strand; must be ≥1.
- LED_ADDRESS_WIDTH, 6, LED index width; index ports are LED_ADDRESS_WIDTH+1 bits.
- SETTLE_FRAMES, 3, camera frames discarded after the LED update before a capture; must be ≥1.
- TIMEOUT_CYCLES, 1048576, watchdog limit (used only with CAL_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic is single-domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a sweep from IDLE, DONE or ERROR.
- abort  in  1  pulse; cancels any sweep and returns to IDLE.
- led_frame_displayed  in  1  pulse from the LED driver: strand refreshed with the current ID.
- cam_frame_done  in  1  pulse: camera finished writing one frame to the frame buffer.
- capture_done  in  1  pulse: calibration FSM finished scanning/recording the captured frame.
- led_index  out  LED_ADDRESS_WIDTH+1  LED currently lit.
- show_valid  out  1  high while led_index should be displayed.
- capture_req  out  1  one-cycle pulse requesting capture of the current frame.
- busy  out  1  high in every state except IDLE, DONE, ERROR.
- done  out  1  high in DONE.
- error  out  1  high in ERROR (timeout builds only; tied 0 otherwise).

## Operation
States: IDLE, WAIT_LED, SETTLE, CAPTURE, WAIT_CAP, NEXT, DONE, ERROR.
- IDLE: outputs inactive. start → WAIT_LED with led_index=0.
- WAIT_LED: show_valid=1; led_frame_displayed → SETTLE, frame counter cleared.
- SETTLE: show_valid=1; each cam_frame_done increments the counter; on the SETTLE_FRAMES-th pulse → CAPTURE.
- CAPTURE: capture_req=1 for exactly this cycle → WAIT_CAP.
- WAIT_CAP: show_valid=1; capture_done → NEXT.
- NEXT: if led_index == NUM_LEDS-1 → DONE; else led_index+1 → WAIT_LED.
- DONE: show_valid=0, done=1, led_index holds the last value; start restarts the sweep from 0.
- ERROR: entered on timeout; error=1; start restarts from 0; abort → IDLE.
- abort has priority over every other input in every state: next state IDLE, led_index=0.
- start is ignored while busy.
- Pulses are counted only in the state that consumes them; early capture_done or led_frame_displayed pulses are dropped.
- The frame counter is $clog2(SETTLE_FRAMES+1) bits wide; the index compare is done at full LED_ADDRESS_WIDTH+1 width.

## Timing
- Reset: state IDLE, led_index=0, all other outputs 0.
- All outputs are registered from state/counters; there is no combinational input→output path.
- start → WAIT_LED (show_valid=1) on the next clock edge.
- The SETTLE_FRAMES-th cam_frame_done → CAPTURE next cycle; capture_req is asserted one cycle after that pulse.
- capture_done → NEXT next cycle → WAIT_LED with the new index on the following cycle (2 cycles per index step).
- NUM_LEDS=1: NEXT goes straight to DONE.
- Reset asserted mid-sweep clears everything immediately, with no pending capture_req.

## Configuration
- CAL_SEQ_TIMEOUT_EN defined:
  - A watchdog counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on every state entry.
  - In WAIT_LED, SETTLE or WAIT_CAP, reaching TIMEOUT_CYCLES without the awaited pulse → ERROR.
- CAL_SEQ_TIMEOUT_EN undefined:
  - No counter; ERROR is unreachable and error is constant 0.
  - The sequencer waits indefinitely.

## Test plan
- NUM_LEDS=4, SETTLE_FRAMES=3, ideal responders → led_index steps 0,1,2,3; exactly 4 capture_req pulses, each after the 3rd cam_frame_done; done=1, busy=0.
- 2 cam_frame_done pulses, then capture_done, while in SETTLE → no capture_req; stays in SETTLE until the 3rd frame.
- abort in WAIT_CAP at index 2, asserted the same cycle as capture_done → IDLE, led_index=0, no NEXT.
- start while busy at index 1 → ignored; sweep continues at index 1.
- CAL_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no capture_done → error=1 16 cycles after WAIT_CAP entry; start restarts at index 0.
- rst_n low mid-SETTLE for 1 cycle → all outputs 0 immediately; start then sweeps normally from 0.

Source files
------------

// File: rtl/cal_sweep_sequencer_if.sv
// Control/handshake bundle between the user side, LED driver, camera and the
// calibration sweep sequencer. master drives the pulses; slave is the sequencer.
interface cal_sweep_sequencer_if #(
    parameter int unsigned LED_ADDRESS_WIDTH = 6
);
    logic                       start;
    logic                       abort;
    logic                       led_frame_displayed;
    logic                       cam_frame_done;
    logic                       capture_done;
    logic [LED_ADDRESS_WIDTH:0] led_index;
    logic                       show_valid;
    logic                       capture_req;
    logic                       busy;
    logic                       done;
    logic                       error;

    modport master (
        output start,
        output abort,
        output led_frame_displayed,
        output cam_frame_done,
        output capture_done,
        input  led_index,
        input  show_valid,
        input  capture_req,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  abort,
        input  led_frame_displayed,
        input  cam_frame_done,
        input  capture_done,
        output led_index,
        output show_valid,
        output capture_req,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/cal_sweep_sequencer.sv
// Timed, handshaked LED calibration sweep: light LED n, wait for the strand and camera
// to settle, request a capture, step to n+1. Define CAL_SEQ_TIMEOUT_EN for the watchdog.
module cal_sweep_sequencer #(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned LED_ADDRESS_WIDTH = 6,
    parameter int unsigned SETTLE_FRAMES     = 3,
    parameter int unsigned TIMEOUT_CYCLES    = 1048576
) (
    input logic                  clk,
    input logic                  rst_n,
    cal_sweep_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_FRAMES + 1);

    localparam logic [IDX_W-1:0] LAST_INDEX   = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] SETTLE_COUNT = CNT_W'(SETTLE_FRAMES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitLed,
        StSettle,
        StCapture,
        StWaitCap,
        StNext,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   led_index_q, led_index_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   frame_cnt_inc;

    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

`ifdef CAL_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              waiting;
    logic              wdog_expired;

    assign waiting      = (state_q == StWaitLed) || (state_q == StSettle) ||
                          (state_q == StWaitCap);
    assign wdog_expired = waiting && (wdog_q == WDOG_LAST);
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            led_index_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            led_index_q <= led_index_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        led_index_d = led_index_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (bus.start) begin
                    state_d     = StWaitLed;
                    led_index_d = '0;
                    frame_cnt_d = '0;
                end
            end
            StWaitLed: begin
                if (bus.led_frame_displayed) begin
                    state_d     = StSettle;
                    frame_cnt_d = '0;
                end
            end
            StSettle: begin
                if (bus.cam_frame_done) begin
                    frame_cnt_d = frame_cnt_inc;
                    if (frame_cnt_inc == SETTLE_COUNT) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                state_d = StWaitCap;
            end
            StWaitCap: begin
                if (bus.capture_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (led_index_q == LAST_INDEX) begin
                    state_d = StDone;
                end else begin
                    state_d     = StWaitLed;
                    led_index_d = led_index_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef CAL_SEQ_TIMEOUT_EN
        // The awaited pulse on the final cycle still wins over the watchdog.
        if (wdog_expired && (state_d == state_q)) begin
            state_d = StError;
        end
`endif

        if (bus.abort) begin
            state_d     = StIdle;
            led_index_d = '0;
            frame_cnt_d = '0;
        end
    end

`ifdef CAL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Restarts on every state entry; only runs while waiting on an external pulse.
    always_comb begin
        wdog_d = '0;
        if ((state_d == state_q) && waiting) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    assign bus.error = (state_q == StError);
`else
    assign bus.error = 1'b0;
`endif

    // The strand stays lit for the whole step, including the capture and index update.
    assign bus.led_index   = led_index_q;
    assign bus.busy        = (state_q != StIdle) && (state_q != StDone) &&
                             (state_q != StError);
    assign bus.show_valid  = bus.busy;
    assign bus.capture_req = (state_q == StCapture);
    assign bus.done        = (state_q == StDone);

endmodule
